// File: rtl/dvp_pixel_capture_pkg.sv
// Shared types and constants for the DVP capture path.
// No logic; FSM encoding, pixel word layout and counter widths.
package dvp_capture_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_VSYNC = 2'd1;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd2;
    localparam logic [1:0] ST_FRAME      = 2'd3;

    localparam int PIX_W      = 18;
    localparam int LINE_CNT_W = 10;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [15:0] data;
    } pix_word_t;

    function automatic logic [LINE_CNT_W-1:0] line_inc(input logic [LINE_CNT_W-1:0] v);
        return (&v) ? v : v + LINE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/dvp_pixel_capture_if.sv
// Pixel stream: 16-bit RGB565 word with frame/line tags, valid/ready handshake.
// Data and tags hold stable while valid is high and ready is low.
interface dvp_pixel_capture_if;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_valid;
    logic        pix_ready;

    modport master (output pix_data, output pix_sof, output pix_eol, output pix_valid,
                    input  pix_ready);
    modport slave  (input  pix_data, input  pix_sof, input  pix_eol, input  pix_valid,
                    output pix_ready);
endinterface

// File: rtl/dvp_pixel_capture_fifo.sv
// Generic synchronous show-ahead FIFO with full/empty flags.
// Latency 1 cycle push-to-valid; push while full is accepted only with a same-cycle pop.
module pixel_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             empty, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop_rdy & ~empty;
    assign do_push = push_vld & (~full | do_pop);
    assign pop_vld = ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge PCLK) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dvp_pixel_capture.sv
// OV7670 DVP capture: oversampled camera bus, RGB565 byte pairing, sof/eol tagging, pixel FIFO.
// Latency <= SYNC_STAGES+3 PCLK from second-byte cam_pclk edge; full FIFO drops pixels (sticky overflow).
module dvp_pixel_capture
    import dvp_capture_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  enable,
    input  logic                  cfg_done,
    input  logic                  err_clr,
    input  logic                  cam_pclk,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic [7:0]            cam_data,
    dvp_pixel_capture_if.master   pix,
    output logic                  frame_done,
    output logic [LINE_CNT_W-1:0] line_count,
    output logic                  overflow,
    output logic                  size_err
);
    localparam int                    PCW    = $clog2(H_ACTIVE + 1);
    localparam logic [PCW-1:0]        H_LAST = PCW'(H_ACTIVE - 1);
    localparam logic [PCW-1:0]        H_FULL = PCW'(H_ACTIVE);
    localparam logic [LINE_CNT_W-1:0] V_FULL = LINE_CNT_W'(V_ACTIVE);

    logic [SYNC_STAGES-1:0] pclk_sync, vsync_sync, href_sync;
    logic [7:0]             data_sync [SYNC_STAGES];
    logic                   pclk_prev, vsync_smp, href_smp;

    logic [1:0]     state;
    logic           phase, sof_pend;
    logic [7:0]     byte_hi;
    logic [PCW-1:0] pixel_cnt;

    logic       pclk_rise, vsync_now, href_now, in_frame, run_ok;
    logic       hr_fall, vs_rise, vs_fall, pix_stb, in_window, push, pop, push_lost, size_set;
    logic       fifo_full, fifo_vld;
    logic [7:0] byte_now;
    logic [PIX_W-1:0] fifo_dat;
    pix_word_t  push_word, head;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pclk_sync  <= '0;
            vsync_sync <= '0;
            href_sync  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
            pclk_prev  <= 1'b0;
            vsync_smp  <= 1'b0;
            href_smp   <= 1'b0;
        end else begin
            pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], cam_pclk};
            vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], cam_vsync};
            href_sync  <= {href_sync[SYNC_STAGES-2:0], cam_href};
            data_sync[0] <= cam_data;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
            pclk_prev  <= pclk_sync[SYNC_STAGES-1];
            if (pclk_rise) begin
                vsync_smp <= vsync_now;
                href_smp  <= href_now;
            end
        end
    end

    // vsync/href edges are judged between successive camera-clock samples only
    assign pclk_rise = pclk_sync[SYNC_STAGES-1] & ~pclk_prev;
    assign vsync_now = vsync_sync[SYNC_STAGES-1];
    assign href_now  = href_sync[SYNC_STAGES-1];
    assign byte_now  = data_sync[SYNC_STAGES-1];
    assign hr_fall   = pclk_rise & ~href_now & href_smp;
    assign vs_rise   = pclk_rise & vsync_now & ~vsync_smp;
    assign vs_fall   = pclk_rise & ~vsync_now & vsync_smp;

    assign in_frame  = (state == ST_FRAME);
    assign run_ok    = enable & cfg_done;
    assign pix_stb   = in_frame & pclk_rise & href_now & phase;
    assign in_window = (pixel_cnt < H_FULL) && (line_count < V_FULL);
    assign push      = pix_stb & in_window;
    assign pop       = fifo_vld & pix.pix_ready;
    assign push_lost = push & fifo_full & ~pop;
    assign size_set  = in_frame & ((pix_stb & ~in_window)
                     | (hr_fall & (phase | (pixel_cnt != H_FULL)))
                     | (vs_rise & (line_count != V_FULL)));

    assign push_word = '{sof: sof_pend, eol: (pixel_cnt == H_LAST), data: {byte_hi, byte_now}};

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            phase      <= 1'b0;
            sof_pend   <= 1'b0;
            byte_hi    <= '0;
            pixel_cnt  <= '0;
            line_count <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            size_err   <= 1'b0;
        end else begin
            frame_done <= in_frame & vs_rise;
            overflow   <= push_lost | (overflow & ~err_clr);
            size_err   <= size_set  | (size_err & ~err_clr);
            case (state)
                ST_IDLE: if (run_ok) state <= ST_WAIT_VSYNC;
                ST_WAIT_VSYNC: begin
                    if (!run_ok)                     state <= ST_IDLE;
                    else if (pclk_rise && vsync_now) state <= ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (!run_ok) state <= ST_IDLE;
                    else if (vs_fall) begin
                        state      <= ST_FRAME;
                        line_count <= '0;
                        pixel_cnt  <= '0;
                        phase      <= 1'b0;
                        sof_pend   <= 1'b1;
                    end
                end
                ST_FRAME: begin
                    if (pclk_rise && href_now) begin
                        if (!phase) begin
                            byte_hi <= byte_now;
                            phase   <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (pixel_cnt != H_FULL) pixel_cnt <= pixel_cnt + PCW'(1);
                        end
                    end
                    // sof stays armed until a tagged pixel actually lands in the FIFO
                    if (push && (!fifo_full || pop)) sof_pend <= 1'b0;
                    if (hr_fall) begin
                        line_count <= line_inc(line_count);
                        pixel_cnt  <= '0;
                        phase      <= 1'b0;
                    end
                    if (vs_rise) state <= run_ok ? ST_WAIT_FRAME : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pixel_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .push_vld (push),
        .push_dat (push_word),
        .full     (fifo_full),
        .pop_rdy  (pix.pix_ready),
        .pop_vld  (fifo_vld),
        .pop_dat  (fifo_dat)
    );

    assign head          = pix_word_t'(fifo_dat);
    assign pix.pix_valid = fifo_vld;
    assign pix.pix_data  = fifo_vld ? head.data : 16'h0000;
    assign pix.pix_sof   = fifo_vld & head.sof;
    assign pix.pix_eol   = fifo_vld & head.eol;
endmodule

// File: tb/tb_dvp_pixel_capture.sv
// Camera-model bench for dvp_pixel_capture with a frame-level pixel/error reference model.
module tb_dvp_pixel_capture;
    import dvp_capture_pkg::*;

    localparam int H = 4, V = 3, SS = 2, FD = 8;

    logic       PCLK = 1'b0;
    logic       PRESET, enable, cfg_done, err_clr;
    logic       cam_pclk, cam_vsync, cam_href;
    logic [7:0] cam_data;
    logic       frame_done, overflow, size_err;
    logic [9:0] line_count;

    dvp_pixel_capture_if pix_if();

    dvp_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(SS), .FIFO_DEPTH(FD)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .enable(enable), .cfg_done(cfg_done), .err_clr(err_clr),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .pix(pix_if), .frame_done(frame_done), .line_count(line_count),
        .overflow(overflow), .size_err(size_err));

    always #5 PCLK = ~PCLK;

    int total = 0, passed = 0;
    logic [17:0] exp_q[$], rx_q[$];
    logic [7:0]  cur_line[$];
    int  line_len[8];
    int  fd_cnt, hold_viol, exp_frames, exp_lines;
    bit  exp_size_err, mcapt, msof;
    logic pv_before_rst, pv_after_rst;
    logic [9:0] lc_after_rst;
    logic [2:0] flags_after_rst;

    initial begin : monitor
        logic stall;
        logic [17:0] prev_w, w;
        stall = 1'b0;
        prev_w = '0;
        forever begin
            @(negedge PCLK);
            w = {pix_if.pix_sof, pix_if.pix_eol, pix_if.pix_data};
            if (stall && (!pix_if.pix_valid || w !== prev_w)) hold_viol++;
            if (pix_if.pix_valid && pix_if.pix_ready) rx_q.push_back(w);
            if (frame_done) fd_cnt++;
            stall  = pix_if.pix_valid && !pix_if.pix_ready;
            prev_w = w;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cam_cycle(input logic vs, input logic hr, input logic [7:0] d);
        cam_vsync = vs; cam_href = hr; cam_data = d; cam_pclk = 1'b0;
        repeat (2) @(negedge PCLK);
        cam_pclk = 1'b1;
        repeat (2) @(negedge PCLK);
    endtask

    task automatic blank(input int n, input logic vs);
        repeat (n) cam_cycle(vs, 1'b0, 8'h00);
    endtask

    task automatic set_ready(input logic v);
        @(posedge PCLK); #1 pix_if.pix_ready = v;
    endtask

    task automatic pulse_err_clr();
        @(posedge PCLK); #1 err_clr = 1'b1;
        @(posedge PCLK); #1 err_clr = 1'b0;
    endtask

    task automatic clear_sb();
        pulse_err_clr();
        rx_q.delete(); exp_q.delete();
        fd_cnt = 0; hold_viol = 0; exp_frames = 0; exp_size_err = 0;
        for (int i = 0; i < 8; i++) line_len[i] = 2 * H;
    endtask

    task automatic do_hook(input int kind);
        case (kind)
            1: cfg_done = 1'b1;
            2: begin
                pv_before_rst = pix_if.pix_valid;
                @(posedge PCLK); #1 PRESET = 1'b1;
                @(posedge PCLK); #1 PRESET = 1'b0;
                pv_after_rst    = pix_if.pix_valid;
                lc_after_rst    = line_count;
                flags_after_rst = {overflow, size_err, frame_done};
                rx_q.delete(); exp_q.delete();
                fd_cnt = 0; exp_frames = 0; exp_size_err = 0; mcapt = 0;
            end
            3: enable = 1'b0;
            default: ;
        endcase
    endtask

    // Reference: pair bytes per line, keep pixels inside the HxV window, tag sof/eol.
    task automatic model_line(input int l);
        int npx;
        if (!mcapt) return;
        npx = cur_line.size() / 2;
        if ((cur_line.size() % 2) != 0 || npx != H) exp_size_err = 1;
        for (int k = 0; k < npx; k++) begin
            if (k < H && l < V) begin
                exp_q.push_back({msof, (k == H - 1), cur_line[2*k], cur_line[2*k+1]});
                msof = 0;
            end else exp_size_err = 1;
        end
    endtask

    task automatic send_frame(input int nl, input bit rnd, input bit capt,
                              input int hk_line, input int hk_kind);
        logic [7:0] d;
        int b;
        b = 1;
        blank(3, 1'b1);
        blank(3, 1'b0);
        mcapt = capt; msof = 1;
        for (int l = 0; l < nl; l++) begin
            cur_line.delete();
            for (int k = 0; k < line_len[l]; k++) begin
                if (l == hk_line && k == 3) do_hook(hk_kind);
                d = rnd ? 8'($urandom) : 8'(b);
                b++;
                cur_line.push_back(d);
                cam_cycle(1'b0, 1'b1, d);
            end
            blank(3, 1'b0);
            model_line(l);
        end
        blank(2, 1'b0);
        if (mcapt) begin
            exp_frames++;
            exp_lines = nl;
            if (nl != V) exp_size_err = 1;
        end
        blank(2, 1'b1);
    endtask

    task automatic test_reset();
        PRESET = 1'b1; enable = 1'b0; cfg_done = 1'b0; err_clr = 1'b0;
        cam_pclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
        pix_if.pix_ready = 1'b1;
        repeat (4) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        total++; if (pix_if.pix_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", pix_if.pix_valid); else passed++;
        total++; if (pix_if.pix_data !== 16'h0) $display("FAIL reset_data got %h want 0000", pix_if.pix_data); else passed++;
        total++; if ({pix_if.pix_sof, pix_if.pix_eol} !== 2'b00) $display("FAIL reset_tags got %b want 00", {pix_if.pix_sof, pix_if.pix_eol}); else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else passed++;
        total++; if (line_count !== 10'd0) $display("FAIL reset_line_count got %0d want 0", line_count); else passed++;
        total++; if ({overflow, size_err} !== 2'b00) $display("FAIL reset_errs got %b want 00", {overflow, size_err}); else passed++;
        enable = 1'b1; cfg_done = 1'b1;
        repeat (4) @(negedge PCLK);
    endtask

    task automatic test_nominal();
        clear_sb();
        send_frame(3, 1'b0, 1'b1, -1, 0);
        repeat (30) @(negedge PCLK);
        total++; if (rx_q.size() != exp_q.size()) $display("FAIL nominal_count got %0d want %0d", rx_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) $display("FAIL nominal_pix[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else passed++;
        end
        if (rx_q.size() >= 12) begin
            total++; if (rx_q[0] !== 18'h20102) $display("FAIL nominal_first got %h want 20102", rx_q[0]); else passed++;
            total++; if (rx_q[11] !== 18'h11718) $display("FAIL nominal_last got %h want 11718", rx_q[11]); else passed++;
        end
        total++; if (fd_cnt != exp_frames) $display("FAIL nominal_frame_done got %0d want %0d", fd_cnt, exp_frames); else passed++;
        total++; if (line_count !== 10'(exp_lines)) $display("FAIL nominal_line_count got %0d want %0d", line_count, exp_lines); else passed++;
        total++; if (size_err !== exp_size_err) $display("FAIL nominal_size_err got %b want %b", size_err, exp_size_err); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL nominal_overflow got %b want 0", overflow); else passed++;
    endtask

    task automatic test_back_to_back();
        bit stop;
        clear_sb();
        stop = 0;
        fork
            begin
                send_frame(3, 1'b1, 1'b1, -1, 0);
                send_frame(3, 1'b1, 1'b1, -1, 0);
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge PCLK); #1 pix_if.pix_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        set_ready(1'b1);
        repeat (30) @(negedge PCLK);
        total++; if (rx_q.size() != exp_q.size()) $display("FAIL b2b_count got %0d want %0d", rx_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) $display("FAIL b2b_pix[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else passed++;
        end
        total++; if (hold_viol != 0) $display("FAIL b2b_hold_stable got %0d changes want 0", hold_viol); else passed++;
        total++; if (fd_cnt != exp_frames) $display("FAIL b2b_frame_done got %0d want %0d", fd_cnt, exp_frames); else passed++;
        total++; if (size_err !== exp_size_err) $display("FAIL b2b_size_err got %b want %b", size_err, exp_size_err); else passed++;
    endtask

    task automatic test_odd_line();
        clear_sb();
        line_len[1] = 2 * H - 1;
        send_frame(3, 1'b0, 1'b1, -1, 0);
        repeat (30) @(negedge PCLK);
        total++; if (rx_q.size() != 11) $display("FAIL odd_count got %0d want 11", rx_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) $display("FAIL odd_pix[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else passed++;
        end
        total++; if (size_err !== exp_size_err) $display("FAIL odd_size_err got %b want %b", size_err, exp_size_err); else passed++;
        total++; if (line_count !== 10'(exp_lines)) $display("FAIL odd_line_count got %0d want %0d", line_count, exp_lines); else passed++;
        pulse_err_clr();
        @(negedge PCLK);
        total++; if (size_err !== 1'b0) $display("FAIL odd_err_clr got %b want 0", size_err); else passed++;
    endtask

    task automatic test_overflow();
        clear_sb();
        set_ready(1'b0);
        send_frame(3, 1'b0, 1'b1, -1, 0);
        repeat (10) @(negedge PCLK);
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passed++;
        total++; if (pix_if.pix_valid !== 1'b1) $display("FAIL ovf_valid got %b want 1", pix_if.pix_valid); else passed++;
        set_ready(1'b1);
        repeat (20) @(negedge PCLK);
        total++; if (rx_q.size() != FD) $display("FAIL ovf_drain_count got %0d want %0d", rx_q.size(), FD); else passed++;
        for (int i = 0; i < FD && i < rx_q.size() && i < exp_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) $display("FAIL ovf_pix[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else passed++;
        end
        total++; if (size_err !== exp_size_err) $display("FAIL ovf_size_err got %b want %b", size_err, exp_size_err); else passed++;
        pulse_err_clr();
        @(negedge PCLK);
        total++; if (overflow !== 1'b0) $display("FAIL ovf_err_clr got %b want 0", overflow); else passed++;
    endtask

    task automatic test_cfg_mid();
        clear_sb();
        @(posedge PCLK); #1 cfg_done = 1'b0;
        repeat (4) @(negedge PCLK);
        send_frame(3, 1'b1, 1'b0, 1, 1);
        send_frame(3, 1'b1, 1'b1, -1, 0);
        repeat (30) @(negedge PCLK);
        total++; if (rx_q.size() != exp_q.size()) $display("FAIL cfg_count got %0d want %0d", rx_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) $display("FAIL cfg_pix[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else passed++;
        end
        if (rx_q.size() > 0) begin
            total++; if (rx_q[0][17] !== 1'b1) $display("FAIL cfg_first_sof got %b want 1", rx_q[0][17]); else passed++;
        end
        total++; if (fd_cnt != exp_frames) $display("FAIL cfg_frame_done got %0d want %0d", fd_cnt, exp_frames); else passed++;
    endtask

    task automatic test_preset_mid();
        clear_sb();
        set_ready(1'b0);
        send_frame(3, 1'b0, 1'b1, 1, 2);
        set_ready(1'b1);
        total++; if (pv_before_rst !== 1'b1) $display("FAIL rst_valid_before got %b want 1", pv_before_rst); else passed++;
        total++; if (pv_after_rst !== 1'b0) $display("FAIL rst_valid_after got %b want 0", pv_after_rst); else passed++;
        total++; if (lc_after_rst !== 10'd0) $display("FAIL rst_line_count got %0d want 0", lc_after_rst); else passed++;
        total++; if (flags_after_rst !== 3'b000) $display("FAIL rst_flags got %b want 000", flags_after_rst); else passed++;
        total++; if (rx_q.size() != 0) $display("FAIL rst_no_pixels got %0d want 0", rx_q.size()); else passed++;
        send_frame(3, 1'b0, 1'b1, -1, 0);
        repeat (30) @(negedge PCLK);
        total++; if (rx_q.size() != exp_q.size()) $display("FAIL rst_resume_count got %0d want %0d", rx_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) $display("FAIL rst_pix[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else passed++;
        end
        total++; if (fd_cnt != exp_frames) $display("FAIL rst_frame_done got %0d want %0d", fd_cnt, exp_frames); else passed++;
    endtask

    task automatic test_enable_drop();
        clear_sb();
        send_frame(3, 1'b0, 1'b1, 1, 3);
        send_frame(3, 1'b0, 1'b0, -1, 0);
        repeat (30) @(negedge PCLK);
        total++; if (rx_q.size() != exp_q.size()) $display("FAIL endrop_count got %0d want %0d", rx_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) $display("FAIL endrop_pix[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else passed++;
        end
        total++; if (fd_cnt != exp_frames) $display("FAIL endrop_frame_done got %0d want %0d", fd_cnt, exp_frames); else passed++;
        total++; if (line_count !== 10'(exp_lines)) $display("FAIL endrop_line_count got %0d want %0d", line_count, exp_lines); else passed++;
        total++; if (pix_if.pix_valid !== 1'b0) $display("FAIL endrop_valid got %b want 0", pix_if.pix_valid); else passed++;
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_odd_line();
        test_overflow();
        test_cfg_mid();
        test_preset_mid();
        test_enable_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
